// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared opcodes and state encoding for the vector sequencer
//
// Purpose: opcode nibble constants and the sequencer FSM state type.
// Ports:   none (package).
package vec_pkg;

  localparam logic [3:0] OP_LABS = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hB;
  localparam logic [3:0] OP_JSRL = 4'hC;
  localparam logic [3:0] OP_RTSL = 4'hD;
  localparam logic [3:0] OP_JMPL = 4'hE;
  localparam logic [3:0] OP_SVEC = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH0 = 3'd1,
    ST_DEC0   = 3'd2,
    ST_FETCH1 = 3'd3,
    ST_DEC1   = 3'd4,
    ST_RUN    = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

endpackage

// File: rtl/vec_ret_stack.sv
// rtl/vec_ret_stack.sv - wrapping return-address LIFO for subroutine calls
//
// Purpose: DEPTH-entry return stack; the pointer wraps silently on both
//          overflow (oldest entry overwritten) and underflow.
// Ports:   clk_i, resetn_i  clock and synchronous active-low reset
//          clear_i          reset the pointer only (program restart)
//          push_i/push_data_i  write entry at sp, then sp+1
//          pop_i            sp-1
//          top_o            entry at sp-1 (the value a pop returns)
module vec_ret_stack #(
  parameter int AW    = 13,
  parameter int DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          resetn_i,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [AW-1:0] push_data_i,
  output logic [AW-1:0] top_o
);

  localparam int SPW = $clog2(DEPTH);

  logic [AW-1:0]  mem_q [DEPTH];
  logic [SPW-1:0] sp_q;
  logic [SPW-1:0] sp_dec;

  // Modular decrement: sp=0 reads the last entry.
  assign sp_dec = sp_q - SPW'(1);
  assign top_o  = mem_q[sp_dec];

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      sp_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear_i) begin
      sp_q <= '0;
    end else if (push_i) begin
      mem_q[sp_q] <= push_data_i;
      sp_q        <= sp_q + SPW'(1);
    end else if (pop_i) begin
      sp_q <= sp_dec;
    end
  end

endmodule

// File: rtl/vec_sequencer.sv
// rtl/vec_sequencer.sv - display-list fetch/decode sequencer driving the vector timer
//
// Purpose: fetches one- or two-word instructions, loads the vector timer,
//          runs it until stop, and handles JSRL/RTSL/JMPL/HALT.
// Ports:   clk, reset (sync active-low), dvg_go start pulse, halted status
//          mem_req/mem_addr/mem_ack/mem_data  vector memory read port
//          timer_val/scale/dvx11/dvy11/latch0/1/2/go/stop  timer interface
//          op_word0/op_word1  registered instruction words
module vec_sequencer
  import vec_pkg::*;
#(
  parameter int AW          = 13,
  parameter int STACK_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dvg_go,
  output logic          halted,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [15:0]   mem_data,
  output logic [3:0]    timer_val,
  output logic [3:0]    scale,
  output logic          dvx11,
  output logic          dvy11,
  output logic          latch0,
  output logic          latch1,
  output logic          latch2,
  output logic          go,
  input  logic          stop,
  output logic [15:0]   op_word0,
  output logic [15:0]   op_word1
);

  state_e        state_q;
  logic [AW-1:0] pc_q;
  logic [15:0]   op_word0_q, op_word1_q;
  logic [3:0]    timer_val_q, scale_q;
  logic          latch0_q, latch1_q, latch2_q, go_q;

  logic [3:0]    opcode;
  logic          stk_push, stk_pop, stk_clear;
  logic [AW-1:0] stk_top;

  assign opcode    = op_word0_q[15:12];
  assign stk_clear = ((state_q == ST_IDLE) || (state_q == ST_HALT)) && dvg_go;
  assign stk_push  = (state_q == ST_DEC1) && (opcode == OP_JSRL);
  assign stk_pop   = (state_q == ST_DEC0) && (opcode == OP_RTSL);

  vec_ret_stack #(
    .AW   (AW),
    .DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk_i      (clk),
    .resetn_i   (reset),
    .clear_i    (stk_clear),
    .push_i     (stk_push),
    .pop_i      (stk_pop),
    .push_data_i(pc_q),
    .top_o      (stk_top)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      op_word0_q  <= '0;
      op_word1_q  <= '0;
      timer_val_q <= '0;
      scale_q     <= '0;
      latch0_q    <= 1'b0;
      latch1_q    <= 1'b0;
      latch2_q    <= 1'b0;
      go_q        <= 1'b0;
    end else begin
      latch0_q <= 1'b0;
      latch1_q <= 1'b0;
      latch2_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_HALT: begin
          if (dvg_go) begin
            pc_q    <= '0;
            state_q <= ST_FETCH0;
          end
        end
        ST_FETCH0: begin
          if (mem_ack) begin
            op_word0_q  <= mem_data;
            // Opcode reaches the timer while still in DEC0, so even SVEC
            // gets a go-low preload cycle before RUN.
            timer_val_q <= mem_data[15:12];
            latch0_q    <= 1'b1;
            pc_q        <= pc_q + AW'(1);
            state_q     <= ST_DEC0;
          end
        end
        ST_DEC0: begin
          case (opcode)
            OP_SVEC: begin
              go_q    <= 1'b1;
              state_q <= ST_RUN;
            end
            OP_HALT: state_q <= ST_HALT;
            OP_RTSL: begin
              pc_q    <= stk_top;
              state_q <= ST_FETCH0;
            end
            default: state_q <= ST_FETCH1;  // VCTR 0-9, LABS, JSRL, JMPL
          endcase
        end
        ST_FETCH1: begin
          if (mem_ack) begin
            op_word1_q <= mem_data;
            latch1_q   <= 1'b1;
            pc_q       <= pc_q + AW'(1);
            state_q    <= ST_DEC1;
          end
        end
        ST_DEC1: begin
          case (opcode)
            OP_LABS: begin
              // latch2 is asserted together with the new scale value.
              scale_q  <= op_word1_q[15:12];
              latch2_q <= 1'b1;
              state_q  <= ST_FETCH0;
            end
            OP_JSRL, OP_JMPL: begin
              pc_q    <= op_word1_q[AW-1:0];
              state_q <= ST_FETCH0;
            end
            default: begin
              go_q    <= 1'b1;
              state_q <= ST_RUN;
            end
          endcase
        end
        ST_RUN: begin
          if (stop) begin
            go_q    <= 1'b0;
            state_q <= ST_FETCH0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign halted    = (state_q == ST_IDLE) || (state_q == ST_HALT);
  assign mem_req   = (state_q == ST_FETCH0) || (state_q == ST_FETCH1);
  assign mem_addr  = pc_q;
  assign timer_val = timer_val_q;
  assign scale     = scale_q;
  assign dvx11     = op_word0_q[10];
  assign dvy11     = op_word0_q[2];
  assign latch0    = latch0_q;
  assign latch1    = latch1_q;
  assign latch2    = latch2_q;
  assign go        = go_q;
  assign op_word0  = op_word0_q;
  assign op_word1  = op_word1_q;

endmodule

// File: tb/tb_vec_sequencer.sv
// tb/tb_vec_sequencer.sv - self-checking bench for vec_sequencer
module tb_vec_sequencer;

  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          dvg_go = 1'b0;
  logic          mem_ack = 1'b0;
  logic [15:0]   mem_data = '0;
  logic          stop = 1'b0;
  logic          halted, mem_req, dvx11, dvy11, latch0, latch1, latch2, go;
  logic [AW-1:0] mem_addr;
  logic [3:0]    timer_val, scale;
  logic [15:0]   op_word0, op_word1;

  vec_sequencer #(.AW(AW), .STACK_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .dvg_go(dvg_go), .halted(halted),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .timer_val(timer_val), .scale(scale), .dvx11(dvx11), .dvy11(dvy11),
    .latch0(latch0), .latch1(latch1), .latch2(latch2), .go(go), .stop(stop),
    .op_word0(op_word0), .op_word1(op_word1)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:(1<<AW)-1];
  int exp_q[$];
  int checks = 0;
  int errors = 0;
  int ack_delay = 0, wait_cnt = 0, run_len = 5, run_cnt = 0;
  bit stop_en = 1'b1;
  int cyc = 0, go_cycles = 0, l0_cyc = 0, l1_cyc = 0, l2_count = 0;
  logic [3:0] l2_tv, l2_scale, tv_at_go;
  logic l2_go, sv_dvx, sv_dvy;
  bit go_first = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory acks only while the scoreboard expects a fetch; an unexpected
  // fetch therefore stalls and surfaces as a timeout.
  always @(negedge clk) begin
    cyc++;
    mem_ack = 1'b0;
    stop = 1'b0;
    if (reset && mem_req && exp_q.size() > 0) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack = 1'b1;
        mem_data = mem[mem_addr];
        chk("fetch_addr", 32'(mem_addr), exp_q.pop_front());
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    if (go) begin
      if (!go_first) begin
        tv_at_go = timer_val;
        sv_dvx = dvx11;
        sv_dvy = dvy11;
        go_first = 1'b1;
      end
      go_cycles++;
      run_cnt++;
      if (stop_en && run_cnt >= run_len) begin
        stop = 1'b1;
        run_cnt = 0;
      end
    end else begin
      run_cnt = 0;
    end
    if (latch0 && l0_cyc == 0) l0_cyc = cyc;
    if (latch1 && l1_cyc == 0) l1_cyc = cyc;
    if (latch2) begin
      l2_count++;
      l2_tv = timer_val;
      l2_scale = scale;
      l2_go = go;
    end
  end

  task automatic clear_stats();
    go_cycles = 0; l0_cyc = 0; l1_cyc = 0; l2_count = 0; go_first = 1'b0;
    exp_q.delete();
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'hB000;
  endtask

  task automatic start();
    @(negedge clk) dvg_go = 1'b1;
    @(negedge clk) dvg_go = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    int n = 0;
    while (!halted && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_halted"}, 32'(halted), 32'd1);
  endtask

  initial begin
    int n;
    clear_stats();
    repeat (3) @(negedge clk);
    chk("rst_halted", 32'(halted), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_go", 32'(go), 32'd0);
    chk("rst_latches", 32'({latch0, latch1, latch2}), 32'd0);
    chk("rst_timer_val", 32'(timer_val), 32'd0);
    chk("rst_scale", 32'(scale), 32'd0);
    chk("rst_op_words", {op_word0, op_word1}, 32'd0);
    @(negedge clk) reset = 1'b1;

    // Immediate HALT
    clear_stats();
    exp_q = {0};
    start();
    wait_halt("t1");
    chk("t1_go_cycles", go_cycles, 0);
    chk("t1_timer_val", 32'(timer_val), 32'hB);
    chk("t1_q_empty", exp_q.size(), 0);

    // Two-word VCTR with slow memory
    clear_stats();
    mem[0] = 16'h7123; mem[1] = 16'h4456; mem[2] = 16'hB000;
    ack_delay = 3;
    exp_q = {0, 1, 2};
    start();
    wait_halt("t2");
    chk("t2_tv_at_go", 32'(tv_at_go), 32'h7);
    chk("t2_latch0_seen", 32'(l0_cyc != 0), 32'd1);
    chk("t2_latch1_after_latch0", l1_cyc - l0_cyc, 5);
    chk("t2_go_cycles", go_cycles, run_len);
    chk("t2_op_word1", 32'(op_word1), 32'h4456);
    chk("t2_q_empty", exp_q.size(), 0);

    // LABS
    clear_stats();
    ack_delay = 0;
    mem[0] = 16'hA010; mem[1] = 16'h3020; mem[2] = 16'hB000;
    exp_q = {0, 1, 2};
    start();
    wait_halt("t3");
    chk("t3_latch2_count", l2_count, 1);
    chk("t3_latch2_tv", 32'(l2_tv), 32'hA);
    chk("t3_latch2_scale", 32'(l2_scale), 32'h3);
    chk("t3_latch2_go", 32'(l2_go), 32'd0);
    chk("t3_go_cycles", go_cycles, 0);
    chk("t3_q_empty", exp_q.size(), 0);

    // JSRL / SVEC / RTSL
    clear_stats();
    mem[0] = 16'hC000; mem[1] = 16'h0010; mem[16] = 16'hF404; mem[17] = 16'hD000;
    mem[2] = 16'hB000;
    exp_q = {0, 1, 16, 17, 2};
    start();
    wait_halt("t4");
    chk("t4_go_cycles", go_cycles, run_len);
    chk("t4_tv_at_go", 32'(tv_at_go), 32'hF);
    chk("t4_dvx11", 32'(sv_dvx), 32'd1);
    chk("t4_dvy11", 32'(sv_dvy), 32'd1);
    chk("t4_q_empty", exp_q.size(), 0);

    // Five nested calls then returns: the stack wraps, so the fifth return
    // reuses 66 and the following RTSL pops stack[3]=50.
    clear_stats();
    mem[0] = 16'hC000;  mem[1] = 16'h0010;
    mem[16] = 16'hC000; mem[17] = 16'h0020;
    mem[32] = 16'hC000; mem[33] = 16'h0030;
    mem[48] = 16'hC000; mem[49] = 16'h0040;
    mem[64] = 16'hC000; mem[65] = 16'h0050;
    mem[80] = 16'hD000; mem[66] = 16'hD000; mem[50] = 16'hD000;
    mem[34] = 16'hD000; mem[18] = 16'hD000;
    exp_q = {0, 1, 16, 17, 32, 33, 48, 49, 64, 65, 80, 66, 50, 34, 18, 66};
    start();
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("t5_q_empty", exp_q.size(), 0);
    repeat (4) @(negedge clk);
    chk("t5_mem_req", 32'(mem_req), 32'd1);
    chk("t5_wrap_addr", 32'(mem_addr), 32'd50);
    reset = 1'b0;
    @(negedge clk) reset = 1'b1;

    // Reset during RUN, then restart
    clear_stats();
    stop_en = 1'b0;
    mem[0] = 16'h0000; mem[1] = 16'h0000;
    exp_q = {0, 1};
    start();
    n = 0;
    while (!go && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t6_go_before_reset", 32'(go), 32'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_go_after_reset", 32'(go), 32'd0);
    chk("t6_halted_after_reset", 32'(halted), 32'd1);
    chk("t6_mem_req_after_reset", 32'(mem_req), 32'd0);
    @(negedge clk) reset = 1'b1;
    stop_en = 1'b1;
    clear_stats();
    exp_q = {0};
    start();
    wait_halt("t6r");
    chk("t6r_q_empty", exp_q.size(), 0);
    chk("t6r_go_cycles", go_cycles, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_sequencer.md
Name: vec_sequencer

Overview:
- Instruction sequencer for the vector generator: fetches 16-bit display-list words, decodes opcodes, loads the vector timer and runs it.
- Drives the vector timer's timer_val/scale/dvx11/dvy11/latch2/go inputs and waits on its stop output.
- Supports one- and two-word instructions, subroutine call/return through a 4-entry return stack, jumps and halt.
- Sits between the vector memory port and the timer/position datapath.

Parameters:
- AW, 13, word address width of the vector memory.
- STACK_DEPTH, 4, return stack entries; must be a power of two.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- dvg_go  in  1  start pulse; begins execution at address 0.
- halted  out  1  high in IDLE/HALT.
- mem_req  out  1  read request; held until mem_ack.
- mem_addr  out  AW  word address; stable while mem_req is high.
- mem_ack  in  1  mem_data is valid this cycle.
- mem_data  in  16  read data.
- timer_val  out  4  opcode nibble to the timer.
- scale  out  4  scale field (word1[15:12] of LABS).
- dvx11  out  1  bit 10 of word0 (SVEC sign select).
- dvy11  out  1  bit 2 of word0 (SVEC sign select).
- latch0  out  1  one-cycle strobe: word0 valid on op_word0.
- latch1  out  1  one-cycle strobe: word1 valid on op_word1.
- latch2  out  1  one-cycle strobe: scale/label update.
- go  out  1  timer run enable.
- stop  in  1  timer terminal count.
- op_word0  out  16  registered first word.
- op_word1  out  16  registered second word.

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; pc, sp and all stack entries 0.
  - halted=1, mem_req=0, go=0, all latch strobes 0.
  - timer_val=0, scale=0, op_word0/1=0.
- States: IDLE, FETCH0, DEC0, FETCH1, DEC1, RUN, HALT.
- IDLE/HALT + dvg_go=1: pc<=0, sp<=0, go to FETCH0. dvg_go is ignored in every other state.
- FETCH0/FETCH1:
  - mem_req=1, mem_addr=pc.
  - On the mem_ack cycle: capture mem_data into op_word0/1, pc<=pc+1 (wraps mod 2^AW), go to DEC0/DEC1.
  - No ack means wait indefinitely.
- DEC0 decodes opcode = op_word0[15:12]; timer_val<=opcode; latch0 pulses.
  - 0-9 (VCTR), A (LABS), C (JSRL), E (JMPL): go to FETCH1.
  - F (SVEC): go to RUN.
  - B (HALT): go to HALT.
  - D (RTSL): sp<=sp-1; pc<=stack[sp-1]; go to FETCH0.
- DEC1 pulses latch1, then dispatches on opcode:
  - VCTR: go to RUN.
  - LABS: scale<=op_word1[15:12]; latch2 pulses this cycle with timer_val=A; go to FETCH0.
  - JSRL: stack[sp]<=pc; sp<=sp+1; pc<=op_word1[AW-1:0]; go to FETCH0.
  - JMPL: pc<=op_word1[AW-1:0]; go to FETCH0.
- go is low in all states except RUN, so the timer preloads while timer_val is stable. At least one go-low cycle is guaranteed after timer_val changes.
- RUN:
  - go=1 from the first RUN cycle.
  - When stop==1 is sampled in RUN: go<=0 on the next edge and state goes to FETCH0.
  - stop is ignored outside RUN.
- Stack pointer is log2(STACK_DEPTH) bits and wraps.
  - Overflow (5th nested JSRL) overwrites the oldest entry.
  - Underflow (RTSL with sp=0) reads stack[DEPTH-1].
  - Neither condition flags an error.
- dvx11/dvy11 are combinational from op_word0.
- Reset mid-fetch or mid-RUN returns to IDLE on the same edge; mem_req and go drop on that edge.

Decomposition:
- Package vec_pkg:
  - opcode localparams OP_LABS=4'hA, OP_HALT=4'hB, OP_JSRL=4'hC, OP_RTSL=4'hD, OP_JMPL=4'hE, OP_SVEC=4'hF.
  - state encoding.
- One sub-module, vec_ret_stack: parameterized LIFO with push/pop/wrap and no error outputs.

Test Plan:
- Reset, then dvg_go with mem[0]=16'hB000 → FETCH0 at addr 0, then HALT; halted=1 and go never asserted.
- mem[0]=16'h7123, mem[1]=16'h4456, mem[2]=16'hB000, mem_ack delayed 3 cycles → timer_val=7, latch0 then latch1, go high until 1 cycle after stop, then fetch at addr 2.
- mem[0]=16'hA010, mem[1]=16'h3020 → latch2 pulses with timer_val=A and scale=3; go stays 0.
- mem[0]=16'hC000, mem[1]=16'h0010; mem[16]=16'hF000 (SVEC), mem[17]=16'hD000, mem[2]=16'hB000 → fetch order 0,1,16,17,2; sp returns to 0.
- Five nested JSRLs followed by five RTSLs → fifth return lands at the address overwritten by the wrap; no hang.
- Assert reset during RUN with stop never firing → go=0 and halted=1 on the next edge; a subsequent dvg_go restarts at addr 0.
